// File: rtl/shift_reg_input_pkg.sv
// Package for the shift_reg_input serial receiver.
//
// Pulls in the shared glyph table and state encodings from seven_seg_defs.vh
// and wraps the encodings in the FSM state type. Also provides the digit
// select decoder used when SHIFT_REG_INPUT_SEG_DECODE_EN is defined.

package shift_reg_input_pkg;

`include "seven_seg_defs.vh"

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        SHIFT = ST_SHIFT,
        FULL  = ST_FULL,
        OVER  = ST_OVER
    } state_t;

    // Returns {ok, index}. Only a single bit set within bits 0..2 is a
    // legal select; anything else (zero, multi-hot, bits 3..7) is rejected.
    function automatic logic [2:0] decode_select(input logic [7:0] sel_byte);
        logic [2:0] result;
        case (sel_byte)
            8'h01:   result = 3'b1_00;
            8'h02:   result = 3'b1_01;
            8'h04:   result = 3'b1_10;
            default: result = 3'b0_00;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/seg_to_hex.sv
// Combinational seven-segment glyph to hex nibble decoder.
//
// Ports:
//   segments  in   8  glyph byte {dp,g,f,e,d,c,b,a}
//   nibble    out  4  hex value of the glyph (0 when not a glyph)
//   valid     out  1  segments matched one of the 16 glyphs
//
// Instantiated by shift_reg_input only when SHIFT_REG_INPUT_SEG_DECODE_EN
// is defined.

module seg_to_hex
    import shift_reg_input_pkg::*;
(
    input  logic [7:0] segments,
    output logic [3:0] nibble,
    output logic       valid
);

    // All 16 glyphs are distinct, so at most one table entry can match.
    always_comb begin
        nibble = 4'd0;
        valid  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (segments == GLYPH_TABLE[i]) begin
                nibble = 4'(i);
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seven_seg_defs.vh
// Shared seven-segment and FSM definitions for the serial display link.
//
// Included inside a package body, so everything here is a package-scope
// localparam. The encoder side of the link uses the same glyph table, so
// a word built there decodes here without translation.
//
// Glyph encoding is {dp, g, f, e, d, c, b, a}, active high, dp always 0.
// FSM encodings: IDLE=0, SHIFT=1, FULL=2, OVER=3.

`ifndef SEVEN_SEG_DEFS_VH
`define SEVEN_SEG_DEFS_VH

localparam logic [7:0] GLYPH_0 = 8'h3F;
localparam logic [7:0] GLYPH_1 = 8'h06;
localparam logic [7:0] GLYPH_2 = 8'h5B;
localparam logic [7:0] GLYPH_3 = 8'h4F;
localparam logic [7:0] GLYPH_4 = 8'h66;
localparam logic [7:0] GLYPH_5 = 8'h6D;
localparam logic [7:0] GLYPH_6 = 8'h7D;
localparam logic [7:0] GLYPH_7 = 8'h07;
localparam logic [7:0] GLYPH_8 = 8'h7F;
localparam logic [7:0] GLYPH_9 = 8'h6F;
localparam logic [7:0] GLYPH_A = 8'h77;
localparam logic [7:0] GLYPH_B = 8'h7C;
localparam logic [7:0] GLYPH_C = 8'h39;
localparam logic [7:0] GLYPH_D = 8'h5E;
localparam logic [7:0] GLYPH_E = 8'h79;
localparam logic [7:0] GLYPH_F = 8'h71;

// Index i holds the glyph that displays hex digit i.
localparam logic [7:0] GLYPH_TABLE [16] = '{
    GLYPH_0, GLYPH_1, GLYPH_2, GLYPH_3, GLYPH_4, GLYPH_5, GLYPH_6, GLYPH_7,
    GLYPH_8, GLYPH_9, GLYPH_A, GLYPH_B, GLYPH_C, GLYPH_D, GLYPH_E, GLYPH_F
};

localparam logic [1:0] ST_IDLE  = 2'd0;
localparam logic [1:0] ST_SHIFT = 2'd1;
localparam logic [1:0] ST_FULL  = 2'd2;
localparam logic [1:0] ST_OVER  = 2'd3;

`endif

// File: rtl/shift_reg_input.sv
// Receive end of the 3-wire serial link (data, data clock, latch).
//
// The three wires are asynchronous to i_clk. Each passes a SYNC_STAGES-deep
// synchronizer and a registered rising-edge detector; the FSM then shifts
// in one bit per data-clock edge and commits the word on a latch edge.
// A word is good only if exactly 2**DATA_WIDTH bits arrived since the last
// latch, timeout or reset. Extra bits keep shifting (last N kept) but the
// frame is still rejected, like a 74HC595 that was over-clocked.
//
// Optional feature macro: SHIFT_REG_INPUT_SEG_DECODE_EN
//   When defined, each committed word is decoded as {select byte, glyph
//   byte} into a digit index and hex value. When undefined the decode
//   outputs are tied to 0.
//
// Ports:
//   i_clk         in   1   system clock
//   i_reset_n     in   1   asynchronous reset, active low
//   i_data_val    in   1   serial data (async)
//   i_data_clock  in   1   serial shift clock (async), data taken on rise
//   i_latch       in   1   latch strobe (async), frame committed on rise
//   o_value       out  N   last good frame, MSB = first bit received
//   o_valid       out  1   one-cycle pulse, o_value updated
//   o_frame_err   out  1   one-cycle pulse, bad bit count at latch/timeout
//   o_busy        out  1   a frame is in progress
//   o_digit_val   out  4   decoded hex digit
//   o_digit_sel   out  2   decoded digit index
//   o_decode_err  out  1   last committed word was not decodable

module shift_reg_input
    import shift_reg_input_pkg::*;
#(
    parameter int DATA_WIDTH    = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int FRAME_TIMEOUT = 4096
) (
    input  logic                       i_clk,
    input  logic                       i_reset_n,
    input  logic                       i_data_val,
    input  logic                       i_data_clock,
    input  logic                       i_latch,
    output logic [2**DATA_WIDTH-1:0]   o_value,
    output logic                       o_valid,
    output logic                       o_frame_err,
    output logic                       o_busy,
    output logic [3:0]                 o_digit_val,
    output logic [1:0]                 o_digit_sel,
    output logic                       o_decode_err
);

    localparam int N  = 2**DATA_WIDTH;
    localparam int CW = DATA_WIDTH + 1;
    localparam int IW = $clog2(FRAME_TIMEOUT) + 1;

    localparam logic [CW-1:0] CNT_FULL   = CW'(N);
    localparam logic [CW-1:0] CNT_OVER   = CW'(N + 1);
    localparam logic [IW-1:0] IDLE_LIMIT = IW'(FRAME_TIMEOUT - 1);

    if (SYNC_STAGES < 2) begin : g_sync_check
        $error("shift_reg_input: SYNC_STAGES must be at least 2");
    end

    // Bit order in every synchronizer stage: {latch, data clock, data}.
    logic [2:0] raw_in;
    assign raw_in = {i_latch, i_data_clock, i_data_val};

    // Plain flop chain per input; each stage lives in its own generate
    // scope so no array is driven from more than one process.
    for (genvar g = 0; g < SYNC_STAGES; g++) begin : g_sync
        logic [2:0] q;
        if (g == 0) begin : g_first
            always_ff @(posedge i_clk or negedge i_reset_n) begin
                if (!i_reset_n) q <= 3'b000;
                else            q <= raw_in;
            end
        end else begin : g_next
            always_ff @(posedge i_clk or negedge i_reset_n) begin
                if (!i_reset_n) q <= 3'b000;
                else            q <= g_sync[g-1].q;
            end
        end
    end

    logic [2:0] sync_out;
    assign sync_out = g_sync[SYNC_STAGES-1].q;

    logic [2:0] sync_prev;
    logic       dclk_rise;
    logic       latch_rise;
    logic       data_bit;

    // Registered edge detect. data_bit is registered alongside so the bit
    // shifted in is the one present when the data clock was seen rising.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sync_prev  <= 3'b000;
            dclk_rise  <= 1'b0;
            latch_rise <= 1'b0;
            data_bit   <= 1'b0;
        end else begin
            sync_prev  <= sync_out;
            dclk_rise  <= sync_out[1] & ~sync_prev[1];
            latch_rise <= sync_out[2] & ~sync_prev[2];
            data_bit   <= sync_out[0];
        end
    end

    state_t          state;
    logic [N-1:0]    sr;
    logic [CW-1:0]   count;
    logic [IW-1:0]   idle_cnt;

    state_t          state_next;
    logic [N-1:0]    sr_next;
    logic [CW-1:0]   count_next;
    logic            commit;
    logic            timeout;

    // Effect of a data-clock edge alone. The latch decision below looks at
    // these values, so a shift and a latch in the same cycle count the
    // shifted bit before judging the frame.
    always_comb begin
        sr_next    = sr;
        count_next = count;
        state_next = state;
        if (dclk_rise) begin
            sr_next = {sr[N-2:0], data_bit};
            case (state)
                IDLE: begin
                    count_next = CW'(1);
                    state_next = SHIFT;
                end
                SHIFT: begin
                    count_next = count + 1'b1;
                    state_next = (count + 1'b1 == CNT_FULL) ? FULL : SHIFT;
                end
                FULL, OVER: begin
                    count_next = CNT_OVER;
                    state_next = OVER;
                end
                default: begin
                    count_next = CNT_OVER;
                    state_next = OVER;
                end
            endcase
        end
    end

    assign commit  = latch_rise && (count_next == CNT_FULL);
    assign timeout = !latch_rise && !dclk_rise && (state != IDLE)
                     && (idle_cnt == IDLE_LIMIT);

    // Main FSM. Latch wins over timeout; a data-clock edge restarts the
    // idle counter, so a timeout can only fire on an otherwise quiet cycle.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state       <= IDLE;
            sr          <= '0;
            count       <= '0;
            idle_cnt    <= '0;
            o_value     <= '0;
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
            sr          <= sr_next;
            if (latch_rise) begin
                state    <= IDLE;
                count    <= '0;
                idle_cnt <= '0;
                if (commit) begin
                    o_value <= sr_next;
                    o_valid <= 1'b1;
                end else begin
                    o_frame_err <= 1'b1;
                end
            end else if (timeout) begin
                state       <= IDLE;
                count       <= '0;
                idle_cnt    <= '0;
                o_frame_err <= 1'b1;
            end else begin
                state    <= state_next;
                count    <= count_next;
                idle_cnt <= (dclk_rise || state == IDLE) ? '0 : idle_cnt + 1'b1;
            end
        end
    end

    assign o_busy = (state != IDLE);

`ifdef SHIFT_REG_INPUT_SEG_DECODE_EN
    if (DATA_WIDTH != 4) begin : g_decode_bad
        $error("shift_reg_input: SHIFT_REG_INPUT_SEG_DECODE_EN needs DATA_WIDTH == 4");
        assign o_digit_val  = 4'd0;
        assign o_digit_sel  = 2'd0;
        assign o_decode_err = 1'b0;
    end else begin : g_decode
        logic [3:0] glyph_nibble;
        logic       glyph_ok;
        logic [2:0] sel_dec;

        // Decode straight from the word being committed so the digit
        // outputs change on the same edge that raises o_valid.
        seg_to_hex u_seg_to_hex (
            .segments (sr_next[7:0]),
            .nibble   (glyph_nibble),
            .valid    (glyph_ok)
        );

        assign sel_dec = decode_select(sr_next[15:8]);

        // Outputs only move on a good frame; rejected frames leave the
        // previous decode in place.
        always_ff @(posedge i_clk or negedge i_reset_n) begin
            if (!i_reset_n) begin
                o_digit_val  <= 4'd0;
                o_digit_sel  <= 2'd0;
                o_decode_err <= 1'b0;
            end else if (commit) begin
                if (glyph_ok && sel_dec[2]) begin
                    o_digit_val  <= glyph_nibble;
                    o_digit_sel  <= sel_dec[1:0];
                    o_decode_err <= 1'b0;
                end else begin
                    o_digit_val  <= 4'd0;
                    o_digit_sel  <= 2'd0;
                    o_decode_err <= 1'b1;
                end
            end
        end
    end
`else
    assign o_digit_val  = 4'd0;
    assign o_digit_sel  = 2'd0;
    assign o_decode_err = 1'b0;
`endif

endmodule

// File: tb/tb_shift_reg_input.sv
// Self-checking bench for shift_reg_input.
//
// A queue holds every bit sent since the last latch, timeout or reset; a
// latch is expected to succeed exactly when the queue holds 16 bits, and
// the expected word is the queue read as a binary number, first bit as MSB.
// Decode outputs are checked when SHIFT_REG_INPUT_SEG_DECODE_EN is defined.

`timescale 1ns/1ps

module tb_shift_reg_input;
    import shift_reg_input_pkg::*;

    localparam int DATA_WIDTH    = 4;
    localparam int SYNC_STAGES   = 2;
    localparam int FRAME_TIMEOUT = 4096;
    localparam int N             = 2**DATA_WIDTH;
    localparam int RESP_EDGE     = SYNC_STAGES + 2;

    logic          clk;
    logic          reset_n;
    logic          data_val;
    logic          data_clock;
    logic          latch;
    logic [N-1:0]  value;
    logic          valid;
    logic          frame_err;
    logic          busy;
    logic [3:0]    digit_val;
    logic [1:0]    digit_sel;
    logic          decode_err;

    int            assertions = 0;
    int            failures   = 0;
    int            both_high  = 0;
    bit            bit_queue[$];
    logic [N-1:0]  exp_value  = '0;

    shift_reg_input #(
        .DATA_WIDTH    (DATA_WIDTH),
        .SYNC_STAGES   (SYNC_STAGES),
        .FRAME_TIMEOUT (FRAME_TIMEOUT)
    ) dut (
        .i_clk         (clk),
        .i_reset_n     (reset_n),
        .i_data_val    (data_val),
        .i_data_clock  (data_clock),
        .i_latch       (latch),
        .o_value       (value),
        .o_valid       (valid),
        .o_frame_err   (frame_err),
        .o_busy        (busy),
        .o_digit_val   (digit_val),
        .o_digit_sel   (digit_sel),
        .o_decode_err  (decode_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulses must never overlap; sampled on the falling edge.
    always @(negedge clk) begin
        if (valid && frame_err) both_high++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        assertions++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    function automatic logic [N-1:0] queueToWord();
        logic [N-1:0] w = '0;
        foreach (bit_queue[i]) w = (w << 1) | N'(bit_queue[i]);
        return w;
    endfunction

    // One serial bit: data set while the data clock is low, then a
    // 3-cycle high phase and a 3-cycle low phase. Ends on a falling edge.
    task automatic applyStimulus(input bit b);
        data_val = b;
        repeat (3) @(negedge clk);
        data_clock = 1'b1;
        bit_queue.push_back(b);
        repeat (3) @(negedge clk);
        data_clock = 1'b0;
    endtask

    task automatic sendBits(input int n, input logic [63:0] w);
        for (int i = n - 1; i >= 0; i--) applyStimulus(w[i]);
    endtask

    // Raises the latch (optionally together with one last data-clock rise)
    // and watches 12 edges for the response pulse.
    task automatic latchAndCheck(input string tag, input bit with_clock, input bit last_bit);
        int  valid_seen = 0;
        int  err_seen   = 0;
        int  first_edge = -1;
        bit  exp_good;
        if (with_clock) begin
            data_val = last_bit;
            repeat (3) @(negedge clk);
            data_clock = 1'b1;
            bit_queue.push_back(last_bit);
        end
        latch = 1'b1;
        exp_good = (bit_queue.size() == N);
        if (exp_good) exp_value = queueToWord();
        bit_queue.delete();
        for (int e = 1; e <= 12; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (valid)     valid_seen++;
            if (frame_err) err_seen++;
            if ((valid || frame_err) && first_edge < 0) first_edge = e;
        end
        latch      = 1'b0;
        data_clock = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput({tag, "_valid_pulses"}, valid_seen, exp_good ? 1 : 0);
        checkOutput({tag, "_err_pulses"},   err_seen,   exp_good ? 0 : 1);
        checkOutput({tag, "_latency"},      first_edge, RESP_EDGE);
        checkOutput({tag, "_value"},        value,      exp_value);
        checkOutput({tag, "_busy"},         busy,       0);
    endtask

    initial begin
        int          first_edge;
        int          valid_seen;
        int          len;
        logic [63:0] w;

        reset_n    = 1'b0;
        data_val   = 1'b0;
        data_clock = 1'b0;
        latch      = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_value", value, 0);
        checkOutput("reset_valid", valid, 0);
        checkOutput("reset_err",   frame_err, 0);
        checkOutput("reset_busy",  busy, 0);
        checkOutput("reset_dec",   {digit_val, digit_sel, decode_err}, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Test 1: good frame.
`ifdef SHIFT_REG_INPUT_SEG_DECODE_EN
        sendBits(16, {48'd0, 8'h01, GLYPH_TABLE[1]});
`else
        sendBits(16, 64'h0106);
`endif
        checkOutput("t1_busy_mid", busy, 1);
        latchAndCheck("t1", 1'b0, 1'b0);
        checkOutput("t1_word", value, 16'h0106);
`ifdef SHIFT_REG_INPUT_SEG_DECODE_EN
        checkOutput("t1_digit_sel", digit_sel, 0);
        checkOutput("t1_digit_val", digit_val, 1);
        checkOutput("t1_decode_err", decode_err, 0);
`else
        checkOutput("t1_decode_tied", {digit_val, digit_sel, decode_err}, 0);
`endif

        // Test 2: short frame.
        sendBits(15, 64'h5555);
        latchAndCheck("t2", 1'b0, 1'b0);

        // Test 3: four extra bits.
        sendBits(20, 64'hABCDE);
        latchAndCheck("t3", 1'b0, 1'b0);

        // Test 4: last data-clock edge coincides with the latch edge.
        sendBits(15, 64'h3C5A >> 1);
        latchAndCheck("t4", 1'b1, 1'b0);
        checkOutput("t4_word", value, 16'h3C5A);

        // Test 5: partial frame left to time out.
        sendBits(7, 64'h55);
        data_val = 1'b1;
        repeat (3) @(negedge clk);
        data_clock = 1'b1;
        bit_queue.push_back(1'b1);
        first_edge = -1;
        valid_seen = 0;
        for (int e = 1; e <= RESP_EDGE + FRAME_TIMEOUT + 20 && first_edge < 0; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (e == 3) data_clock = 1'b0;
            if (valid) valid_seen++;
            if (frame_err) first_edge = e;
        end
        bit_queue.delete();
        checkOutput("t5_timeout_edge", first_edge, RESP_EDGE + FRAME_TIMEOUT);
        checkOutput("t5_no_valid", valid_seen, 0);
        @(negedge clk);
        checkOutput("t5_busy", busy, 0);
        checkOutput("t5_value_held", value, exp_value);
        sendBits(16, 64'h1234);
        latchAndCheck("t5_next", 1'b0, 1'b0);

        // Test 6: reset mid-frame.
        sendBits(9, 64'h1FF);
        reset_n = 1'b0;
        bit_queue.delete();
        exp_value = '0;
        @(negedge clk);
        checkOutput("t6_value", value, 0);
        checkOutput("t6_busy",  busy, 0);
        checkOutput("t6_pulses", {valid, frame_err}, 0);
        checkOutput("t6_dec", {digit_val, digit_sel, decode_err}, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        sendBits(16, 64'hA5C3);
        latchAndCheck("t6", 1'b0, 1'b0);
        checkOutput("t6_word", value, 16'hA5C3);

`ifdef SHIFT_REG_INPUT_SEG_DECODE_EN
        // Select byte with two bits set is not decodable.
        sendBits(16, {48'd0, 8'h03, GLYPH_TABLE[6]});
        latchAndCheck("dec", 1'b0, 1'b0);
        checkOutput("dec_err", decode_err, 1);
`endif

        // Randomized frames around the legal length.
        for (int k = 0; k < 10; k++) begin
            len = 14 + int'($urandom_range(0, 5));
            if (k % 3 == 0) len = N;
            w = {$urandom, $urandom};
            sendBits(len, w);
            latchAndCheck($sformatf("rnd%0d", k), 1'b0, 1'b0);
        end

        checkOutput("pulse_exclusive", both_high, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
